// File: rtl/generic_fifo_pkg.sv
// Shared definitions for the generic FIFO family: read-mode encodings and
// elaboration-time sizing helpers.
package generic_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Width needed to hold a fill count of 0..depth inclusive.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // True for powers of two of at least 2 (pointer wrap relies on this).
  function automatic bit fifo_is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/generic_memory.sv
// Simple dual-port storage array: port A synchronous write, port B
// combinational read. The FIFO control registers whatever it needs.
module generic_memory #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [DATA_WIDTH-1:0] o_b_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Port A write; contents are never reset, the FIFO pointers define validity.
  always_ff @(posedge clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_data;
    end
  end

  assign o_b_data = r_mem[i_b_addr];

endmodule

// File: rtl/generic_fifo_hs.sv
// Synchronous FIFO with valid/ready handshakes on both sides, standard or
// first-word-fall-through read mode, exact count, threshold flags and sticky
// overflow/underflow. In FWFT mode the output register counts as one entry.
module generic_fifo_hs
  import generic_fifo_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int AF_THRESHOLD = DEPTH - 2,
  parameter int AE_THRESHOLD = 1,
  parameter int FWFT         = FIFO_MODE_STD,
  localparam int CW          = fifo_count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  clear,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_ready,
  output logic                  read_valid,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE   = AW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESHOLD);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESHOLD);

  // Reject configurations the pointer/count logic cannot support.
  generate
    if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
      $error("generic_fifo_hs: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESHOLD < 0 || AF_THRESHOLD > DEPTH ||
        AE_THRESHOLD < 0 || AE_THRESHOLD > DEPTH) begin : g_bad_threshold
      $error("generic_fifo_hs: thresholds must lie in 0..DEPTH");
    end
  endgenerate

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_read_valid;
  logic [DATA_WIDTH-1:0] r_read_data;

  logic                  w_wr_en;
  logic                  w_pop;
  logic                  w_mem_rd;
  logic                  w_read_valid_next;
  logic                  w_underflow_hit;
  logic [CW-1:0]         w_count_next;
  logic [DATA_WIDTH-1:0] w_mem_data;

  // write_ready comes from registered full only: no same-cycle pass-through.
  assign w_wr_en = write_valid & ~r_full;

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Entries still in memory exclude the one sitting in the output register.
      logic [CW-1:0] w_mem_count;
      assign w_mem_count       = r_count - CW'(r_read_valid);
      assign w_pop             = r_read_valid & read_ready;
      assign w_mem_rd          = (w_mem_count != '0) & (~r_read_valid | w_pop);
      assign w_read_valid_next = w_mem_rd | (r_read_valid & ~w_pop);
      assign w_underflow_hit   = 1'b0;
    end else begin : g_std
      assign w_pop             = read_ready & ~r_empty;
      assign w_mem_rd          = w_pop;
      assign w_read_valid_next = w_pop;
      assign w_underflow_hit   = read_ready & r_empty;
    end
  endgenerate

  assign w_count_next = r_count + CW'(w_wr_en) - CW'(w_pop);

  generic_memory #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk      (clk),
    .i_a_we   (w_wr_en),
    .i_a_addr (r_wr_ptr),
    .i_a_data (write_data),
    .i_b_addr (r_rd_ptr),
    .o_b_data (w_mem_data)
  );

  // Pointers, count, registered status, sticky errors and the read register.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_af         <= 1'b0;
      r_ae         <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_read_valid <= 1'b0;
      r_read_data  <= '0;
    end else if (clear) begin
      // Flush everything except read_data, which keeps its last value.
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_af         <= 1'b0;
      r_ae         <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_read_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end
      if (w_mem_rd) begin
        r_rd_ptr    <= r_rd_ptr + P_ONE;
        r_read_data <= w_mem_data;
      end
      r_count      <= w_count_next;
      r_full       <= (w_count_next == C_DEPTH);
      r_empty      <= (w_count_next == '0);
      r_af         <= (w_count_next >= C_AF);
      r_ae         <= (w_count_next <= C_AE);
      r_read_valid <= w_read_valid_next;
      if (write_valid & r_full) begin
        r_overflow <= 1'b1;
      end
      if (w_underflow_hit) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign write_ready  = ~r_full;
  assign read_valid   = r_read_valid;
  assign read_data    = r_read_data;
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
